// File: rtl/memory_pkg.sv
// -----------------------------------------------------------------------------
// memory_pkg
// Definitions shared by the data memory responder and its storage array:
// the FSM state encoding, the read/write encoding of read_write_toggle,
// the LDR/STR opcodes used by the controller, and the bus widths.
// Configuration macro honoured elsewhere in this slice: MEM_STATS_EN.
// -----------------------------------------------------------------------------
package memory_pkg;

  localparam int ADDR_BUS_W = 16;
  localparam int DATA_BUS_W = 32;

  // Encoding of read_write_toggle
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Controller opcodes that map onto read / write accesses
  localparam logic [3:0] LDR = 4'b1101;
  localparam logic [3:0] STR = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } mem_state_t;

endpackage : memory_pkg

// File: rtl/data_mem_array.sv
// -----------------------------------------------------------------------------
// data_mem_array
// Word-addressed storage of 2**ADDR_BITS x DATA_BUS_W bits with a synchronous
// write port and a registered read port sharing one address.
//   clk      : clock, all updates on the rising edge
//   reset_n  : synchronous active-low reset (read register only)
//   addr     : word address for both ports
//   wr_en    : write wr_data to addr on this edge
//   wr_data  : write data
//   rd_en    : load the read register on this edge
//   rd_clr   : when loading, load zero instead of the stored word
//   rd_data  : registered read data, holds between loads
// -----------------------------------------------------------------------------
module data_mem_array
  import memory_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic                  wr_en,
  input  logic [DATA_BUS_W-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  rd_clr,
  output logic [DATA_BUS_W-1:0] rd_data
);

  logic [DATA_BUS_W-1:0] mem [2**ADDR_BITS];

  // NOTE: the storage array is deliberately left out of reset; resetting a
  // memory forces it into flops and the contents must survive a reset anyway.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_clr ? '0 : mem[addr];
    end
  end

endmodule : data_mem_array

// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
// Answers single read/write requests from a memory controller. A request seen
// in IDLE is latched, optionally delayed by WAIT_STATES cycles, and completed
// with a one-cycle mem_ack. Addresses beyond 2**ADDR_BITS words are flagged
// with addr_err, never written, and read back as zero.
//
// Parameters:
//   ADDR_BITS   : implemented word-address bits (depth 2**ADDR_BITS, < 16)
//   WAIT_STATES : extra cycles before acknowledge, 0..15
// Ports:
//   clk                  : clock
//   reset_n              : synchronous active-low reset
//   mem_req              : access request, sampled only in IDLE
//   read_write_toggle    : 1 = read (LDR), 0 = write (STR)
//   add_buss_data_access : word address
//   data_bus_out         : write data from the controller
//   data_bus_in          : read data to the controller, held until next read
//   mem_ack              : one-cycle completion strobe
//   mem_busy             : high whenever the FSM is not in IDLE
//   addr_err             : valid with mem_ack, address out of range
//   rd_count / wr_count  : (MEM_STATS_EN only) saturating counts of
//                          successful reads / writes
// Compile-time option: define MEM_STATS_EN to add the access counters.
// -----------------------------------------------------------------------------
module data_memory_responder
  import memory_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_req,
  input  logic                  read_write_toggle,
  input  logic [ADDR_BUS_W-1:0] add_buss_data_access,
  input  logic [DATA_BUS_W-1:0] data_bus_out,
  output logic [DATA_BUS_W-1:0] data_bus_in,
  output logic                  mem_ack,
  output logic                  mem_busy,
`ifdef MEM_STATS_EN
  output logic                  addr_err,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
`else
  output logic                  addr_err
`endif
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  mem_state_t            state;
  logic [3:0]            wait_cnt;
  logic                  lat_rw;
  logic [ADDR_BUS_W-1:0] lat_addr;
  logic [DATA_BUS_W-1:0] lat_data;

  // With no wait states the access completes on the sampling edge itself,
  // so the live inputs stand in for the not-yet-latched copies while in IDLE.
  logic                  cur_rw;
  logic [ADDR_BUS_W-1:0] cur_addr;
  logic [DATA_BUS_W-1:0] cur_data;
  logic                  cur_err;
  logic                  enter_ack;

  assign cur_rw   = (state == IDLE) ? read_write_toggle    : lat_rw;
  assign cur_addr = (state == IDLE) ? add_buss_data_access : lat_addr;
  assign cur_data = (state == IDLE) ? data_bus_out         : lat_data;
  assign cur_err  = (cur_addr >> ADDR_BITS) != '0;

  assign enter_ack = ((state == IDLE) && mem_req && (WAIT_STATES == 0)) ||
                     ((state == WAIT) && (wait_cnt == 4'd0));

  // Array side effects happen only on the edge entering ACK, and a reset on
  // that edge aborts them.
  logic arr_wr_en;
  logic arr_rd_en;

  assign arr_wr_en = reset_n && enter_ack && (cur_rw == RW_WRITE) && !cur_err;
  assign arr_rd_en = reset_n && enter_ack && (cur_rw == RW_READ);

  data_mem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (cur_addr[ADDR_BITS-1:0]),
    .wr_en   (arr_wr_en),
    .wr_data (cur_data),
    .rd_en   (arr_rd_en),
    .rd_clr  (cur_err),
    .rd_data (data_bus_in)
  );

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      mem_ack  <= 1'b0;
      mem_busy <= 1'b0;
      addr_err <= 1'b0;
      lat_rw   <= RW_WRITE;
      lat_addr <= '0;
      lat_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            lat_rw   <= read_write_toggle;
            lat_addr <= add_buss_data_access;
            lat_data <= data_bus_out;
            mem_busy <= 1'b1;
            if (WAIT_STATES == 0) begin
              state    <= ACK;
              mem_ack  <= 1'b1;
              addr_err <= cur_err;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state    <= ACK;
            mem_ack  <= 1'b1;
            addr_err <= cur_err;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ACK: begin
          state    <= IDLE;
          mem_ack  <= 1'b0;
          addr_err <= 1'b0;
          mem_busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          mem_ack  <= 1'b0;
          addr_err <= 1'b0;
          mem_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (enter_ack && !cur_err) begin
      if (cur_rw == RW_READ) begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end else begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end
    end
  end
`endif

endmodule : data_memory_responder

// File: tb/tb_data_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_data_memory_responder
// Three responders share clock, reset and request fields; each has its own
// mem_req. Instance 0: WAIT_STATES=1, instance 1: WAIT_STATES=0,
// instance 2: WAIT_STATES=3, all with ADDR_BITS=8.
// Counter checks are compiled in when MEM_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_data_memory_responder;
  import memory_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rw;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        req  [3];
  logic [31:0] dbi  [3];
  logic        ack  [3];
  logic        busy [3];
  logic        err  [3];
`ifdef MEM_STATS_EN
  logic [15:0] rdc  [3];
  logic [15:0] wrc  [3];
`endif

  int ws_of [3] = '{1, 0, 3};
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.ADDR_BITS(8), .WAIT_STATES(1)) dut0 (
`ifdef MEM_STATS_EN
    .rd_count (rdc[0]), .wr_count (wrc[0]),
`endif
    .clk (clk), .reset_n (reset_n), .mem_req (req[0]),
    .read_write_toggle (rw), .add_buss_data_access (addr),
    .data_bus_out (wdata), .data_bus_in (dbi[0]), .mem_ack (ack[0]),
    .mem_busy (busy[0]), .addr_err (err[0])
  );

  data_memory_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) dut1 (
`ifdef MEM_STATS_EN
    .rd_count (rdc[1]), .wr_count (wrc[1]),
`endif
    .clk (clk), .reset_n (reset_n), .mem_req (req[1]),
    .read_write_toggle (rw), .add_buss_data_access (addr),
    .data_bus_out (wdata), .data_bus_in (dbi[1]), .mem_ack (ack[1]),
    .mem_busy (busy[1]), .addr_err (err[1])
  );

  data_memory_responder #(.ADDR_BITS(8), .WAIT_STATES(3)) dut2 (
`ifdef MEM_STATS_EN
    .rd_count (rdc[2]), .wr_count (wrc[2]),
`endif
    .clk (clk), .reset_n (reset_n), .mem_req (req[2]),
    .read_write_toggle (rw), .add_buss_data_access (addr),
    .data_bus_out (wdata), .data_bus_in (dbi[2]), .mem_ack (ack[2]),
    .mem_busy (busy[2]), .addr_err (err[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete access on instance d, checking busy/ack/err every cycle
  // from the sampling edge until one cycle after ACK.
  task automatic access(input int d, input logic rw_i, input logic [15:0] a,
                        input logic [31:0] wd, input logic exp_err,
                        input logic [31:0] exp_rd);
    @(negedge clk);
    rw = rw_i; addr = a; wdata = wd; req[d] = 1'b1;
    @(negedge clk);
    req[d] = 1'b0;
    for (int c = 0; c <= ws_of[d]; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("d%0d a%h busy c%0d", d, a, c), busy[d], 1'b1);
      check($sformatf("d%0d a%h ack c%0d", d, a, c), ack[d], c == ws_of[d]);
      check($sformatf("d%0d a%h err c%0d", d, a, c), err[d],
            (c == ws_of[d]) ? exp_err : 1'b0);
    end
    if (rw_i == RW_READ) check($sformatf("d%0d a%h rdata", d, a), dbi[d], exp_rd);
    @(negedge clk);
    check($sformatf("d%0d a%h busy after", d, a), busy[d], 1'b0);
    check($sformatf("d%0d a%h ack after", d, a), ack[d], 1'b0);
    check($sformatf("d%0d a%h err after", d, a), err[d], 1'b0);
  endtask

  initial begin
    logic exp_ack [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    reset_n = 1'b0; rw = RW_READ; addr = '0; wdata = '0;
    for (int d = 0; d < 3; d++) req[d] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d reset ack", d),  ack[d],  1'b0);
      check($sformatf("d%0d reset busy", d), busy[d], 1'b0);
      check($sformatf("d%0d reset err", d),  err[d],  1'b0);
      check($sformatf("d%0d reset dbi", d),  dbi[d],  32'h0);
    end
    reset_n = 1'b1;

    // WAIT_STATES=1: write/read-back, hold of data_bus_in, range errors
    access(0, RW_WRITE, 16'h0010, 32'hDEADBEEF, 1'b0, 32'h0);
    access(0, RW_READ,  16'h0010, 32'h0,        1'b0, 32'hDEADBEEF);
    access(0, RW_WRITE, 16'h0011, 32'hCAFEF00D, 1'b0, 32'h0);
    check("d0 hold after write", dbi[0], 32'hDEADBEEF);
    access(0, RW_WRITE, 16'h0000, 32'h00000000, 1'b0, 32'h0);
    access(0, RW_WRITE, 16'h0100, 32'h12345678, 1'b1, 32'h0);
    access(0, RW_READ,  16'h0011, 32'h0,        1'b0, 32'hCAFEF00D);
    access(0, RW_READ,  16'h0100, 32'h0,        1'b1, 32'h0);
    access(0, RW_READ,  16'h0011, 32'h0,        1'b0, 32'hCAFEF00D);
    access(0, RW_READ,  16'h0000, 32'h0,        1'b0, 32'h0);

    // WAIT_STATES=0: request held high across three accesses
    @(negedge clk);
    rw = RW_WRITE; addr = 16'h0001; wdata = 32'hA1A1A1A1; req[1] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("d1 b2b ack %0d", i), ack[1], exp_ack[i]);
      check($sformatf("d1 b2b busy %0d", i), busy[1], exp_ack[i]);
      if (i == 0) begin addr = 16'h0002; wdata = 32'hB2B2B2B2; end
      if (i == 2) begin addr = 16'h0003; wdata = 32'hC3C3C3C3; end
      if (i == 4) req[1] = 1'b0;
    end
    access(1, RW_READ, 16'h0001, 32'h0, 1'b0, 32'hA1A1A1A1);
    access(1, RW_READ, 16'h0002, 32'h0, 1'b0, 32'hB2B2B2B2);
    access(1, RW_READ, 16'h0003, 32'h0, 1'b0, 32'hC3C3C3C3);
    access(1, RW_READ, 16'h0300, 32'h0, 1'b1, 32'h0);

    // WAIT_STATES=3: reset during the second WAIT cycle aborts a write
    access(2, RW_WRITE, 16'h0005, 32'h11111111, 1'b0, 32'h0);
    access(2, RW_READ,  16'h0005, 32'h0,        1'b0, 32'h11111111);
    @(negedge clk);
    rw = RW_WRITE; addr = 16'h0005; wdata = 32'h22222222; req[2] = 1'b1;
    @(negedge clk);
    req[2] = 1'b0;
    check("d2 abort busy w1", busy[2], 1'b1);
    @(negedge clk);
    check("d2 abort busy w2", busy[2], 1'b1);
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("d2 abort ack %0d", i),  ack[2],  1'b0);
      check($sformatf("d2 abort busy %0d", i), busy[2], 1'b0);
      check($sformatf("d2 abort err %0d", i),  err[2],  1'b0);
      check($sformatf("d2 abort dbi %0d", i),  dbi[2],  32'h0);
    end
    check("d0 dbi after reset", dbi[0], 32'h0);
    reset_n = 1'b1;
    access(2, RW_READ, 16'h0005, 32'h0, 1'b0, 32'h11111111);

    // Mix of accesses after reset for the counters
    access(0, RW_READ,  16'h0010, 32'h0,        1'b0, 32'hDEADBEEF);
    access(0, RW_READ,  16'h0011, 32'h0,        1'b0, 32'hCAFEF00D);
    access(0, RW_WRITE, 16'h0012, 32'h55AA55AA, 1'b0, 32'h0);
    access(0, RW_READ,  16'h0200, 32'h0,        1'b1, 32'h0);
`ifdef MEM_STATS_EN
    check("d0 rd_count", {16'h0, rdc[0]}, 32'd2);
    check("d0 wr_count", {16'h0, wrc[0]}, 32'd1);
    check("d2 rd_count", {16'h0, rdc[2]}, 32'd1);
    check("d2 wr_count", {16'h0, wrc[2]}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_data_memory_responder
